icache_direct_mapped: RTL and testbench

//  Parametrised direct-mapped instruction cache: successor to the fixed preloaded ROM instruction store.

---
 rtl/icache_direct_mapped_if.sv | 21 ++
 rtl/icache_direct_mapped.sv | 145 ++++++++++++++
 tb/tb_icache_direct_mapped.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_direct_mapped_if.sv
// Bundles the fetch-side and refill-side handshakes of the direct-mapped instruction cache.
interface icache_direct_mapped_if;
   logic        cpu_req;
   logic [29:0] cpu_addr;
   logic [31:0] cpu_data;
   logic        cpu_stall;
   logic        mem_req;
   logic [29:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output cpu_req, cpu_addr, mem_ack, mem_rdata,
      input  cpu_data, cpu_stall, mem_req, mem_addr
   );

   modport slave (
      input  cpu_req, cpu_addr, mem_ack, mem_rdata,
      output cpu_data, cpu_stall, mem_req, mem_addr
   );
endinterface

// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache with word-by-word line refill, invalidate-all flush
// and hit/miss performance counters.
module icache_direct_mapped #(
   parameter int LINE_WORDS = 4,
   parameter int SETS       = 64,
   parameter int CNT_W      = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   icache_direct_mapped_if.slave  bus,
   output logic [CNT_W-1:0]       hit_cnt,
   output logic [CNT_W-1:0]       miss_cnt
);
   localparam int OFF = $clog2(LINE_WORDS);
   localparam int IDX = $clog2(SETS);
   localparam int TAG = 30 - OFF - IDX;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_REFILL = 1'b1;

   logic [TAG-1:0] tag_mem  [SETS];
   logic [31:0]    data_mem [SETS*LINE_WORDS];

   logic [0:0]       state_q,    state_d;
   logic [SETS-1:0]  valid_q,    valid_d;
   logic [OFF-1:0]   cnt_q,      cnt_d;
   logic             pending_q,  pending_d;
   logic [31:0]      cpu_data_q, cpu_data_d;
   logic             mem_req_q,  mem_req_d;
   logic [29:0]      mem_addr_q, mem_addr_d;
   logic [CNT_W-1:0] hit_cnt_q,  hit_cnt_d;
   logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

   logic [TAG-1:0] req_tag;
   logic [IDX-1:0] req_idx;
   logic [OFF-1:0] req_off;
   logic [IDX-1:0] fill_idx;
   logic           hit;
   logic           miss_start;
   logic           refill_ack;
   logic           last_ack;

   assign req_tag  = bus.cpu_addr[29 -: TAG];
   assign req_idx  = bus.cpu_addr[OFF +: IDX];
   assign req_off  = bus.cpu_addr[OFF-1:0];
   assign fill_idx = mem_addr_q[OFF +: IDX];

   assign hit        = bus.cpu_req & valid_q[req_idx] & (tag_mem[req_idx] == req_tag)
                     & (state_q == ST_IDLE);
   assign miss_start = bus.cpu_req & ~hit & (state_q == ST_IDLE);
   assign refill_ack = (state_q == ST_REFILL) & mem_req_q & bus.mem_ack;
   assign last_ack   = refill_ack & (cnt_q == OFF'(LINE_WORDS - 1));

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      cnt_d      = cnt_q;
      pending_d  = pending_q;
      cpu_data_d = cpu_data_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (flush) begin
               valid_d = '0;
            end
            if (hit) begin
               cpu_data_d = data_mem[{req_idx, req_off}];
               hit_cnt_d  = hit_cnt_q + CNT_W'(1);
            end else if (miss_start) begin
               state_d    = ST_REFILL;
               mem_req_d  = 1'b1;
               mem_addr_d = {req_tag, req_idx, {OFF{1'b0}}};
               cnt_d      = '0;
               miss_cnt_d = miss_cnt_q + CNT_W'(1);
            end
         end
         ST_REFILL: begin
            if (flush) begin
               pending_d = 1'b1;
            end
            if (refill_ack) begin
               cnt_d      = cnt_q + OFF'(1);
               mem_addr_d = mem_addr_q + 30'd1;
            end
            // A flush seen at any point of the refill also kills the line just fetched.
            if (last_ack) begin
               mem_req_d = 1'b0;
               state_d   = ST_IDLE;
               pending_d = 1'b0;
               if (pending_q | flush) begin
                  valid_d = '0;
               end else begin
                  valid_d[fill_idx] = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         valid_q    <= '0;
         cnt_q      <= '0;
         pending_q  <= 1'b0;
         cpu_data_q <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         cnt_q      <= cnt_d;
         pending_q  <= pending_d;
         cpu_data_q <= cpu_data_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   // Arrays carry no reset; the valid bits alone decide whether their contents are used.
   always_ff @(posedge clk) begin
      if (refill_ack) begin
         data_mem[mem_addr_q[OFF+IDX-1:0]] <= bus.mem_rdata;
      end
      if (last_ack) begin
         tag_mem[fill_idx] <= mem_addr_q[29 -: TAG];
      end
   end

   assign bus.cpu_data  = cpu_data_q;
   assign bus.cpu_stall = bus.cpu_req & ~hit;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_addr  = mem_addr_q;
   assign hit_cnt       = hit_cnt_q;
   assign miss_cnt      = miss_cnt_q;
endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed bench for icache_direct_mapped: a behavioural memory answers refills and
// each scenario task checks stall timing, returned data, refill addresses and counters.
module tb_icache_direct_mapped;
   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
   int          total = 0;
   int          bad   = 0;

   icache_direct_mapped_if bus ();

   icache_direct_mapped #(.LINE_WORDS(4), .SETS(64), .CNT_W(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .bus      (bus),
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [29:0] a);
      return {2'b01, a} ^ 32'h5A00_00C3;
   endfunction

   int          ack_delay_max = 0;
   int          wait_cnt      = 0;
   int          ack_count     = 0;
   int          bad_adv       = 0;
   logic [29:0] ack_log [$];
   logic        prev_req  = 1'b0;
   logic        prev_ack  = 1'b0;
   logic [29:0] prev_addr = '0;

   // Memory model: acks on the falling edge, optionally after a random wait, and
   // flags any refill address movement that is not caused by an ack.
   always @(negedge clk) begin
      if (rst) begin
         bus.mem_ack   = 1'b0;
         bus.mem_rdata = '0;
         wait_cnt      = 0;
         prev_req      = 1'b0;
         prev_ack      = 1'b0;
      end else begin
         if (bus.mem_req && prev_req) begin
            if (prev_ack && bus.mem_addr != prev_addr + 30'd1) bad_adv++;
            if (!prev_ack && bus.mem_addr != prev_addr) bad_adv++;
         end
         prev_req    = bus.mem_req;
         prev_addr   = bus.mem_addr;
         prev_ack    = 1'b0;
         bus.mem_ack = 1'b0;
         if (bus.mem_req) begin
            if (wait_cnt == 0) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = mem_word(bus.mem_addr);
               ack_log.push_back(bus.mem_addr);
               ack_count++;
               prev_ack = 1'b1;
               wait_cnt = (ack_delay_max > 0) ? int'($urandom_range(ack_delay_max, 0)) : 0;
            end else begin
               wait_cnt--;
            end
         end
      end
   end

   task automatic do_reset();
      rst          = 1'b1;
      flush        = 1'b0;
      bus.cpu_req  = 1'b0;
      bus.cpu_addr = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Starts and ends just after a rising edge; holds the request until it is accepted.
   task automatic fetch(input logic [29:0] addr, input int flush_at, output int stalls,
                        output logic [31:0] data, output int acks);
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = addr;
      stalls       = 0;
      @(negedge clk);
      while (bus.cpu_stall === 1'b1 && stalls < 200) begin
         stalls++;
         flush = (stalls == flush_at);
         @(negedge clk);
      end
      flush = 1'b0;
      acks  = ack_count;
      total++;
      if (stalls >= 200) begin
         bad++;
         $display("[TB] FAIL fetch_timeout addr=%h: stalled %0d cycles, required acceptance", addr, stalls);
      end
      @(posedge clk);
      #1 bus.cpu_req = 1'b0;
      @(negedge clk);
      data = bus.cpu_data;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      total += 6;
      if (bus.cpu_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_cpu_data: got %h want 0", bus.cpu_data); end
      if (bus.mem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_req: got %b want 0", bus.mem_req); end
      if (bus.mem_addr !== 30'h0) begin bad++; $display("[TB] FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
      if (hit_cnt !== 32'd0) begin bad++; $display("[TB] FAIL reset_hit_cnt: got %0d want 0", hit_cnt); end
      if (miss_cnt !== 32'd0) begin bad++; $display("[TB] FAIL reset_miss_cnt: got %0d want 0", miss_cnt); end
      if (bus.cpu_stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall: got %b want 0", bus.cpu_stall); end
   endtask

   task automatic test_miss_refill();
      int          st;
      int          acks;
      logic [31:0] d;
      ack_log.delete();
      fetch(30'h000, 0, st, d, acks);
      total += 5;
      if (st != 5) begin bad++; $display("[TB] FAIL miss_latency: got %0d stall cycles want 5", st); end
      if (d !== mem_word(30'h000)) begin bad++; $display("[TB] FAIL miss_data: got %h want %h", d, mem_word(30'h000)); end
      if (ack_log.size() != 4) begin bad++; $display("[TB] FAIL miss_reads: got %0d want 4", ack_log.size()); end
      if (miss_cnt !== 32'd1) begin bad++; $display("[TB] FAIL miss_cnt_1: got %0d want 1", miss_cnt); end
      // The held request's final acceptance is itself a hit.
      if (hit_cnt !== 32'd1) begin bad++; $display("[TB] FAIL miss_hit_cnt: got %0d want 1", hit_cnt); end
      for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
         total++;
         if (ack_log[i] !== 30'(i)) begin bad++; $display("[TB] FAIL miss_read_addr%0d: got %h want %h", i, ack_log[i], 30'(i)); end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 1; i <= 3; i++) begin
         bus.cpu_req  = 1'b1;
         bus.cpu_addr = 30'(i);
         @(negedge clk);
         total++;
         if (bus.cpu_stall !== 1'b0) begin bad++; $display("[TB] FAIL b2b_stall%0d: got %b want 0", i, bus.cpu_stall); end
         if (i > 1) begin
            total++;
            if (bus.cpu_data !== mem_word(30'(i - 1))) begin bad++; $display("[TB] FAIL b2b_data%0d: got %h want %h", i - 1, bus.cpu_data, mem_word(30'(i - 1))); end
         end
         @(posedge clk);
         #1;
      end
      bus.cpu_req = 1'b0;
      @(negedge clk);
      total += 3;
      if (bus.cpu_data !== mem_word(30'h3)) begin bad++; $display("[TB] FAIL b2b_data3: got %h want %h", bus.cpu_data, mem_word(30'h3)); end
      if (hit_cnt !== 32'd4) begin bad++; $display("[TB] FAIL b2b_hit_cnt: got %0d want 4", hit_cnt); end
      if (miss_cnt !== 32'd1) begin bad++; $display("[TB] FAIL b2b_miss_cnt: got %0d want 1", miss_cnt); end
      @(posedge clk);
      #1;
      @(negedge clk);
      total++;
      if (bus.cpu_data !== mem_word(30'h3)) begin bad++; $display("[TB] FAIL idle_hold: got %h want %h", bus.cpu_data, mem_word(30'h3)); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_conflict();
      int          st;
      int          acks;
      logic [31:0] d;
      logic [29:0] seq [3];
      seq[0] = 30'h000;
      seq[1] = 30'h100;
      seq[2] = 30'h000;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         fetch(seq[i], 0, st, d, acks);
         total += 2;
         if (st != 5) begin bad++; $display("[TB] FAIL conflict_miss%0d: got %0d stall cycles want 5", i, st); end
         if (d !== mem_word(seq[i])) begin bad++; $display("[TB] FAIL conflict_data%0d: got %h want %h", i, d, mem_word(seq[i])); end
      end
      total++;
      if (miss_cnt !== 32'd3) begin bad++; $display("[TB] FAIL conflict_miss_cnt: got %0d want 3", miss_cnt); end
   endtask

   task automatic test_flush();
      int          st;
      int          acks;
      int          n0;
      logic [31:0] d;
      logic [31:0] m0;
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 30'h002;
      flush        = 1'b1;
      @(negedge clk);
      total++;
      if (bus.cpu_stall !== 1'b0) begin bad++; $display("[TB] FAIL flush_hit_stall: got %b want 0", bus.cpu_stall); end
      @(posedge clk);
      #1;
      flush       = 1'b0;
      bus.cpu_req = 1'b0;
      @(negedge clk);
      total++;
      if (bus.cpu_data !== mem_word(30'h002)) begin bad++; $display("[TB] FAIL flush_hit_data: got %h want %h", bus.cpu_data, mem_word(30'h002)); end
      @(posedge clk);
      #1;
      m0 = miss_cnt;
      fetch(30'h001, 0, st, d, acks);
      total += 2;
      if (st != 5) begin bad++; $display("[TB] FAIL flush_idle_miss: got %0d stall cycles want 5", st); end
      if (miss_cnt !== m0 + 32'd1) begin bad++; $display("[TB] FAIL flush_idle_cnt: got %0d want %0d", miss_cnt, m0 + 32'd1); end
      // A flush during refill forces the held request through a second full refill.
      m0 = miss_cnt;
      n0 = ack_count;
      fetch(30'h040, 2, st, d, acks);
      total += 4;
      if (st != 10) begin bad++; $display("[TB] FAIL flush_refill_stall: got %0d want 10", st); end
      if (d !== mem_word(30'h040)) begin bad++; $display("[TB] FAIL flush_refill_data: got %h want %h", d, mem_word(30'h040)); end
      if (miss_cnt !== m0 + 32'd2) begin bad++; $display("[TB] FAIL flush_refill_cnt: got %0d want %0d", miss_cnt, m0 + 32'd2); end
      if (acks - n0 != 8) begin bad++; $display("[TB] FAIL flush_refill_reads: got %0d want 8", acks - n0); end
      fetch(30'h041, 0, st, d, acks);
      total += 2;
      if (st != 0) begin bad++; $display("[TB] FAIL flush_after_hit: got %0d stall cycles want 0", st); end
      if (d !== mem_word(30'h041)) begin bad++; $display("[TB] FAIL flush_after_data: got %h want %h", d, mem_word(30'h041)); end
   endtask

   task automatic test_slow_mem();
      int          st;
      int          acks;
      int          n0;
      int          adv0;
      logic [31:0] d;
      logic [29:0] addrs [2];
      logic [29:0] base;
      addrs[0] = 30'h080;
      addrs[1] = 30'h0A2;
      ack_delay_max = 5;
      for (int k = 0; k < 2; k++) begin
         base = {addrs[k][29:2], 2'b00};
         n0   = ack_count;
         adv0 = bad_adv;
         ack_log.delete();
         fetch(addrs[k], 0, st, d, acks);
         total += 4;
         if (d !== mem_word(addrs[k])) begin bad++; $display("[TB] FAIL slow_data%0d: got %h want %h", k, d, mem_word(addrs[k])); end
         if (acks - n0 != 4) begin bad++; $display("[TB] FAIL slow_acks_at_accept%0d: got %0d want 4", k, acks - n0); end
         if (st < 5) begin bad++; $display("[TB] FAIL slow_stall%0d: got %0d want >=5", k, st); end
         if (bad_adv != adv0) begin bad++; $display("[TB] FAIL slow_addr_advance%0d: got %0d bad moves want 0", k, bad_adv - adv0); end
         for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
            total++;
            if (ack_log[i] !== base + 30'(i)) begin bad++; $display("[TB] FAIL slow_addr%0d_%0d: got %h want %h", k, i, ack_log[i], base + 30'(i)); end
         end
      end
      ack_delay_max = 0;
   endtask

   task automatic test_reset_mid_refill();
      int          st;
      int          acks;
      int          n0;
      logic [31:0] d;
      do_reset();
      fetch(30'h010, 0, st, d, acks);
      n0 = ack_count;
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 30'h0C0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk);
         #1;
         if (ack_count - n0 >= 2) break;
      end
      total++;
      if (ack_count - n0 != 2) begin bad++; $display("[TB] FAIL rst_mid_acks: got %0d want 2", ack_count - n0); end
      rst         = 1'b1;
      bus.cpu_req = 1'b0;
      @(posedge clk);
      #1;
      total += 4;
      if (bus.mem_req !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_mem_req: got %b want 0", bus.mem_req); end
      if (hit_cnt !== 32'd0) begin bad++; $display("[TB] FAIL rst_mid_hit_cnt: got %0d want 0", hit_cnt); end
      if (miss_cnt !== 32'd0) begin bad++; $display("[TB] FAIL rst_mid_miss_cnt: got %0d want 0", miss_cnt); end
      if (bus.cpu_data !== 32'h0) begin bad++; $display("[TB] FAIL rst_mid_cpu_data: got %h want 0", bus.cpu_data); end
      rst = 1'b0;
      @(posedge clk);
      #1;
      fetch(30'h0C0, 0, st, d, acks);
      total += 3;
      if (st != 5) begin bad++; $display("[TB] FAIL rst_mid_remiss: got %0d stall cycles want 5", st); end
      if (miss_cnt !== 32'd1) begin bad++; $display("[TB] FAIL rst_mid_miss_after: got %0d want 1", miss_cnt); end
      if (d !== mem_word(30'h0C0)) begin bad++; $display("[TB] FAIL rst_mid_data: got %h want %h", d, mem_word(30'h0C0)); end
   endtask

   initial begin
      test_reset();
      test_miss_refill();
      test_back_to_back();
      test_conflict();
      test_flush();
      test_slow_mem();
      test_reset_mid_refill();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
